// File: rtl/bmp_uart_sender.sv
// bmp_uart_sender: streams a 4-bit grayscale frame from the SDRAM read FIFO
// out over UART as a 24-bit bottom-up .bmp file. It sends a 54-byte header,
// then expands each pixel nibble g into three identical bytes {g,g} (B,G,R).
//
// tx handshake: a byte is launched only from SEND and only while tx_ready=1.
// tx_trigger is high for exactly one cycle and tx_data holds until the next
// trigger. After a trigger the block waits for tx_ready to fall (WAIT_BUSY)
// and then to rise again (WAIT_IDLE), so at most one byte is ever in flight.
module bmp_uart_sender #(
    parameter int IMG_WIDTH  = 800,
    parameter int IMG_HEIGHT = 600,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pix_rd,
    input  logic [15:0] pix_in,
    output logic [7:0]  tx_data,
    output logic        tx_trigger,
    input  logic        tx_ready
);

    localparam logic [31:0] ROW_BYTES = 32'(3 * IMG_WIDTH);
    localparam logic [31:0] IMG_SIZE  = ROW_BYTES * 32'(IMG_HEIGHT);
    localparam logic [31:0] FILE_SIZE = 32'd54 + IMG_SIZE;
    localparam int GROUPS = IMG_WIDTH / 4;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int RW     = $clog2(IMG_HEIGHT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_IDLE, S_FETCH, S_WAIT_PIX, S_FIN
    } state_e;

    state_e        state_q, state_d;
    logic          hdr_q, hdr_d;        // 1 while the header is being sent
    logic [5:0]    hidx_q, hidx_d;      // header byte index 0..53
    logic [1:0]    rgb_q, rgb_d;        // copy of the current pixel, 0..2
    logic [1:0]    psel_q, psel_d;      // pixel within the group, 0..3
    logic [GW-1:0] grp_q, grp_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    lat_q, lat_d;
    logic [15:0]   pix_q, pix_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_trig_q, tx_trig_d;
    logic [3:0]    nib;

    // Header byte lookup: little-endian fields, all constant at elaboration.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
        logic [31:0] w;
        logic [5:0]  base;
        logic [5:0]  off;
        w    = 32'd0;
        base = 6'd0;
        if (idx < 6'd2)       begin w = 32'h0000_4D42; base = 6'd0;  end
        else if (idx < 6'd6)  begin w = FILE_SIZE;      base = 6'd2;  end
        else if (idx < 6'd10) begin w = 32'd0;          base = 6'd6;  end
        else if (idx < 6'd14) begin w = 32'd54;         base = 6'd10; end
        else if (idx < 6'd18) begin w = 32'd40;         base = 6'd14; end
        else if (idx < 6'd22) begin w = 32'(IMG_WIDTH);  base = 6'd18; end
        else if (idx < 6'd26) begin w = 32'(IMG_HEIGHT); base = 6'd22; end
        else if (idx < 6'd28) begin w = 32'd1;          base = 6'd26; end
        else if (idx < 6'd30) begin w = 32'd24;         base = 6'd28; end
        else if (idx < 6'd34) begin w = 32'd0;          base = 6'd30; end
        else if (idx < 6'd38) begin w = IMG_SIZE;       base = 6'd34; end
        else if (idx < 6'd42) begin w = 32'd2835;       base = 6'd38; end
        else if (idx < 6'd46) begin w = 32'd2835;       base = 6'd42; end
        off = idx - base;
        w   = w >> {off[1:0], 3'b000};
        return w[7:0];
    endfunction

    assign nib = pix_q[{psel_q, 2'b00} +: 4];

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hdr_q     <= 1'b0;
            hidx_q    <= '0;
            rgb_q     <= '0;
            psel_q    <= '0;
            grp_q     <= '0;
            row_q     <= '0;
            lat_q     <= '0;
            pix_q     <= '0;
            tx_data_q <= '0;
            tx_trig_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            hidx_q    <= hidx_d;
            rgb_q     <= rgb_d;
            psel_q    <= psel_d;
            grp_q     <= grp_d;
            row_q     <= row_d;
            lat_q     <= lat_d;
            pix_q     <= pix_d;
            tx_data_q <= tx_data_d;
            tx_trig_q <= tx_trig_d;
        end
    end

    // Next-state logic: byte handshake, header/pixel sequencing and counters.
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        hidx_d    = hidx_q;
        rgb_d     = rgb_q;
        psel_d    = psel_q;
        grp_d     = grp_q;
        row_d     = row_q;
        lat_d     = lat_q;
        pix_d     = pix_q;
        tx_data_d = tx_data_q;
        tx_trig_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    hdr_d   = 1'b1;
                    hidx_d  = '0;
                    grp_d   = '0;
                    row_d   = '0;
                    rgb_d   = '0;
                    psel_d  = '0;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    tx_trig_d = 1'b1;
                    tx_data_d = hdr_q ? hdr_byte(hidx_q) : {nib, nib};
                    state_d   = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!tx_ready) state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (tx_ready) begin
                    if (hdr_q) begin
                        if (hidx_q == 6'd53) begin
                            hdr_d   = 1'b0;
                            state_d = S_FETCH;
                        end else begin
                            hidx_d  = hidx_q + 6'd1;
                            state_d = S_SEND;
                        end
                    end else if (rgb_q != 2'd2) begin
                        rgb_d   = rgb_q + 2'd1;
                        state_d = S_SEND;
                    end else if (psel_q != 2'd3) begin
                        rgb_d   = 2'd0;
                        psel_d  = psel_q + 2'd1;
                        state_d = S_SEND;
                    end else if (grp_q != GW'(GROUPS - 1)) begin
                        grp_d   = grp_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        // End of a row: the transfer ends once every row is out.
                        grp_d   = '0;
                        row_d   = row_q + 1'b1;
                        state_d = (row_q == RW'(IMG_HEIGHT - 1)) ? S_FIN : S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                lat_d   = 2'd1;
                rgb_d   = 2'd0;
                psel_d  = 2'd0;
                state_d = S_WAIT_PIX;
            end
            S_WAIT_PIX: begin
                // Capture exactly RD_LATENCY cycles after the pix_rd pulse.
                if (lat_q == 2'(RD_LATENCY)) begin
                    pix_d   = pix_in;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign pix_rd     = (state_q == S_FETCH);
    assign tx_data    = tx_data_q;
    assign tx_trigger = tx_trig_q;

endmodule

// File: tb/tb_bmp_uart_sender.sv
// Bench for bmp_uart_sender: two instances (W=4,H=1,lat 1 and W=8,H=2,lat 3),
// each with a UART model, a latency-accurate FIFO model and a byte scoreboard.
module tb_bmp_uart_sender;

    localparam int AW = 4, AH = 1, AL = 1;
    localparam int BW = 8, BH = 2, BL = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start_a, busy_a, done_a, pix_rd_a, trig_a, ready_a;
    logic [15:0] pix_a;
    logic [7:0]  data_a;
    logic        start_b, busy_b, done_b, pix_rd_b, trig_b, ready_b;
    logic [15:0] pix_b;
    logic [7:0]  data_b;

    bmp_uart_sender #(.IMG_WIDTH(AW), .IMG_HEIGHT(AH), .RD_LATENCY(AL)) dut_a (
        .clk_in(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .pix_rd(pix_rd_a), .pix_in(pix_a), .tx_data(data_a), .tx_trigger(trig_a),
        .tx_ready(ready_a));

    bmp_uart_sender #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .RD_LATENCY(BL)) dut_b (
        .clk_in(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .pix_rd(pix_rd_b), .pix_in(pix_b), .tx_data(data_b), .tx_trigger(trig_b),
        .tx_ready(ready_b));

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_a[$], exp_b[$], cap_a[$], cap_b[$];
    int ntrig_a = 0, ntrig_b = 0, nrd_a = 0, nrd_b = 0, ndone_a = 0, ndone_b = 0;
    int ucnt_a = 0, ucnt_b = 0;
    bit stuck_a = 1'b0;
    logic [3:0]  rdp_a = '0, rdp_b = '0;
    logic [15:0] datp_a[4], datp_b[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] src(input bit is_b, input int n);
        return is_b ? 16'(32'h3A5C + n * 32'h0101) : 16'h0F80;
    endfunction

    // Expected file image: header fields re-derived here, then pixel triplets.
    task automatic build_file(input int w, input int h, input bit is_b);
        logic [7:0]  f[$];
        int          isz;
        int          fv[15];
        int          fl[15];
        logic [15:0] v;
        isz = 3 * w * h;
        fv = '{32'h4D42, 54 + isz, 0, 54, 40, w, h, 1, 24, 0, isz, 2835, 2835, 0, 0};
        fl = '{2, 4, 4, 4, 4, 4, 4, 2, 2, 4, 4, 4, 4, 4, 4};
        for (int i = 0; i < 15; i++)
            for (int b = 0; b < fl[i]; b++) f.push_back(8'(fv[i] >> (8 * b)));
        for (int n = 0; n < w * h / 4; n++) begin
            v = src(is_b, n);
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < 3; c++) f.push_back({v[4*k +: 4], v[4*k +: 4]});
        end
        if (is_b) exp_b = f;
        else      exp_a = f;
    endtask

    // UART + FIFO model and scoreboard for instance A (all on the falling edge).
    always @(negedge clk) begin
        if (!rst_n) begin
            ucnt_a = 0;
            rdp_a  = '0;
        end else begin
            if (trig_a) begin
                ntrig_a++;
                cap_a.push_back(data_a);
                check("a_one_outstanding", ucnt_a, 0);
                if (exp_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_byte: got %0h expected no byte", data_a);
                end else begin
                    check("a_byte", data_a, exp_a.pop_front());
                end
            end
            if (trig_a && !stuck_a) ucnt_a = 1;
            else if (ucnt_a != 0)   ucnt_a = (ucnt_a == 12) ? 0 : ucnt_a + 1;
            for (int i = 3; i > 0; i--) datp_a[i] = datp_a[i-1];
            datp_a[0] = src(1'b0, nrd_a);
            rdp_a = {rdp_a[2:0], pix_rd_a};
            if (pix_rd_a) nrd_a++;
            if (done_a) ndone_a++;
        end
        ready_a = !(ucnt_a >= 2 && ucnt_a <= 11);
        pix_a   = rdp_a[AL] ? datp_a[AL] : 16'hDEAD;
    end

    // Same models for instance B.
    always @(negedge clk) begin
        if (!rst_n) begin
            ucnt_b = 0;
            rdp_b  = '0;
        end else begin
            if (trig_b) begin
                ntrig_b++;
                cap_b.push_back(data_b);
                check("b_one_outstanding", ucnt_b, 0);
                if (exp_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_byte: got %0h expected no byte", data_b);
                end else begin
                    check("b_byte", data_b, exp_b.pop_front());
                end
            end
            if (trig_b)           ucnt_b = 1;
            else if (ucnt_b != 0) ucnt_b = (ucnt_b == 12) ? 0 : ucnt_b + 1;
            for (int i = 3; i > 0; i--) datp_b[i] = datp_b[i-1];
            datp_b[0] = src(1'b1, nrd_b);
            rdp_b = {rdp_b[2:0], pix_rd_b};
            if (pix_rd_b) nrd_b++;
            if (done_b) ndone_b++;
        end
        ready_b = !(ucnt_b >= 2 && ucnt_b <= 11);
        pix_b   = rdp_b[BL] ? datp_b[BL] : 16'hDEAD;
    end

    typedef struct {
        int         idx;
        logic [7:0] val;
    } vec_t;

    task automatic wait_done_a(input int limit);
        int cyc;
        cyc = 0;
        while (!done_a && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("a_done_seen", done_a, 1);
    endtask

    initial begin
        vec_t tbl_a[17];
        vec_t tbl_b[8];
        int   cyc;
        bit   ext;
        int   t0;
        tbl_a = '{'{0, 8'h42}, '{1, 8'h4D}, '{2, 8'h42}, '{10, 8'h36}, '{14, 8'h28},
                  '{18, 8'h04}, '{22, 8'h01}, '{26, 8'h01}, '{28, 8'h18}, '{34, 8'h0C},
                  '{38, 8'h13}, '{39, 8'h0B}, '{54, 8'h00}, '{57, 8'h88}, '{60, 8'hFF},
                  '{63, 8'h00}, '{65, 8'h00}};
        tbl_b = '{'{2, 8'h66}, '{18, 8'h08}, '{22, 8'h02}, '{34, 8'h30},
                  '{54, 8'hCC}, '{57, 8'h55}, '{63, 8'h33}, '{90, 8'hFF}};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1; pix_a = 16'hDEAD; pix_b = 16'hDEAD;
        repeat (3) @(negedge clk);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_pix_rd_a", pix_rd_a, 0);
        check("rst_trig_a", trig_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_trig_b", trig_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // A: clean file with extra starts at header byte 10 and at done.
        build_file(AW, AH, 1'b0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_busy_after_start", busy_a, 1);
        cyc = 0; ext = 1'b0;
        while (!done_a && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            if (!ext && cap_a.size() >= 11) begin
                start_a = 1'b1;
                ext = 1'b1;
                check("a_busy_at_extra_start", busy_a, 1);
            end
        end
        check("a_done_seen", done_a, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_busy_after_done", busy_a, 0);
        repeat (50) @(negedge clk);
        check("a_busy_idle", busy_a, 0);
        check("a_trigger_count", ntrig_a, 66);
        check("a_pix_rd_count", nrd_a, 1);
        check("a_done_count", ndone_a, 1);
        check("a_exp_left", exp_a.size(), 0);
        for (int i = 0; i < 17; i++)
            if (tbl_a[i].idx < cap_a.size())
                check($sformatf("a_tbl_byte%0d", tbl_a[i].idx), cap_a[tbl_a[i].idx], tbl_a[i].val);
            else
                check($sformatf("a_tbl_len%0d", tbl_a[i].idx), cap_a.size(), tbl_a[i].idx + 1);

        // B: W=8,H=2, read latency 3, incrementing pixel groups.
        build_file(BW, BH, 1'b1);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 10000) begin
            @(negedge clk);
            cyc++;
        end
        check("b_done_seen", done_b, 1);
        repeat (20) @(negedge clk);
        check("b_trigger_count", ntrig_b, 102);
        check("b_pix_rd_count", nrd_b, 4);
        check("b_done_count", ndone_b, 1);
        check("b_exp_left", exp_b.size(), 0);
        for (int i = 0; i < 8; i++)
            if (tbl_b[i].idx < cap_b.size())
                check($sformatf("b_tbl_byte%0d", tbl_b[i].idx), cap_b[tbl_b[i].idx], tbl_b[i].val);
            else
                check($sformatf("b_tbl_len%0d", tbl_b[i].idx), cap_b.size(), tbl_b[i].idx + 1);

        // A: reset while the UART is shifting pixel byte 5, then a fresh run.
        build_file(AW, AH, 1'b0);
        cap_a.delete();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (!(cap_a.size() >= 60 && !ready_a) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("a_reached_pixel5", cap_a.size(), 60);
        rst_n = 1'b0;
        t0 = ntrig_a;
        #1;
        check("a_abort_busy", busy_a, 0);
        check("a_abort_trig", trig_a, 0);
        check("a_abort_pix_rd", pix_rd_a, 0);
        check("a_abort_data", data_a, 0);
        exp_a.delete();
        ndone_a = 0;
        repeat (3) @(negedge clk);
        check("a_abort_no_trig", ntrig_a, t0);
        rst_n = 1'b1;
        @(negedge clk);
        check("a_abort_no_done", ndone_a, 0);
        build_file(AW, AH, 1'b0);
        cap_a.delete();
        ntrig_a = 0; nrd_a = 0; ndone_a = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(5000);
        repeat (5) @(negedge clk);
        check("a_replay_trigs", ntrig_a, 66);
        check("a_replay_first", (cap_a.size() > 0) ? cap_a[0] : 8'h00, 8'h42);
        check("a_replay_exp_left", exp_a.size(), 0);

        // A: tx_ready never drops after the first trigger.
        stuck_a = 1'b1;
        build_file(AW, AH, 1'b0);
        cap_a.delete();
        ntrig_a = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (ntrig_a == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (300) @(negedge clk);
        check("stuck_one_trigger", ntrig_a, 1);
        check("stuck_still_busy", busy_a, 1);
        rst_n = 1'b0;
        exp_a.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stuck_a = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
